// File: rtl/csv_pkg.sv
// Shared ASCII constants, parser state type and error-bit positions for the CSV record parser.
package csv_pkg;

    localparam logic [7:0] CH_COMMA = 8'h2C;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_SP    = 8'h20;
    localparam logic [7:0] CH_MINUS = 8'h2D;
    localparam logic [7:0] CH_0     = 8'h30;
    localparam logic [7:0] CH_9     = 8'h39;

    typedef enum logic [1:0] {
        FIELD_START,
        DIGITS,
        SKIP
    } parse_state_e;

    localparam int ERR_CHAR = 0;
    localparam int ERR_OVF  = 1;
    localparam int ERR_CNT  = 2;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= CH_0) && (b <= CH_9);
    endfunction

endpackage

// File: rtl/csv_dec_accum.sv
// Decimal accumulator for one field: magnitude multiply-add with sign-dependent
// saturation, and the signed value presented for commit.
module csv_dec_accum
    import csv_pkg::*;
#(
    parameter int FIELD_W = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_clr,
    input  logic                      i_set_neg,
    input  logic                      i_digit_en,
    input  logic [3:0]                i_digit,
    output logic signed [FIELD_W-1:0] o_value,
    output logic                      o_sat
);

    localparam int ACC_W = FIELD_W + 4;
    localparam logic [ACC_W-1:0] LIM_NEG = ACC_W'(1) << (FIELD_W - 1);
    localparam logic [ACC_W-1:0] LIM_POS = LIM_NEG - ACC_W'(1);

    logic [ACC_W-1:0] r_mag;
    logic             r_neg;
    logic [ACC_W-1:0] w_lim;
    logic [ACC_W-1:0] w_next;
    logic [FIELD_W-1:0] w_mag_lo;

    always_comb begin
        w_lim    = r_neg ? LIM_NEG : LIM_POS;
        w_next   = (r_mag * ACC_W'(10)) + ACC_W'(i_digit);
        o_sat    = i_digit_en && (w_next > w_lim);
        w_mag_lo = r_mag[FIELD_W-1:0];
        // magnitude 2^(FIELD_W-1) negates onto itself, which is the most negative value
        o_value  = r_neg ? -w_mag_lo : w_mag_lo;
    end

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_mag <= '0;
            r_neg <= 1'b0;
        end else begin
            if (i_set_neg) begin
                r_neg <= 1'b1;
            end
            if (i_digit_en) begin
                r_mag <= o_sat ? w_lim : w_next;
            end
        end
    end

endmodule

// File: rtl/csv_record_parser.sv
// Streams comma-separated signed decimal lines into fixed-width parallel records
// with per-record error flags and a wrapping record counter.
//   state       | meaning
//   FIELD_START | at start of a field, nothing accumulated yet
//   DIGITS      | sign and/or digits seen, accumulating a field
//   SKIP        | bad character seen, discarding to end of line
module csv_record_parser
    import csv_pkg::*;
#(
    parameter int NUM_FIELDS = 5,
    parameter int FIELD_W    = 32,
    parameter int CNT_W      = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [7:0]                     in_data,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [NUM_FIELDS*FIELD_W-1:0]  out_fields,
    output logic [2:0]                     out_err,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [CNT_W-1:0]               rec_count
);

    localparam int FC_W = $clog2(NUM_FIELDS + 1);

    parse_state_e r_state, w_state_nxt;
    logic [FC_W-1:0] r_fcnt, w_fcnt_nxt;
    logic            r_seen, w_seen_nxt;
    logic [2:0]      r_err, w_rec_err;
    logic [NUM_FIELDS*FIELD_W-1:0] r_wfields, w_rec_fields;

    logic w_accept, w_ign, w_digit_byte, w_room;
    logic w_commit, w_set_neg, w_digit_en, w_bad, w_rec_end;
    logic signed [FIELD_W-1:0] w_value;
    logic w_sat;

    assign in_ready     = !out_valid || out_ready;
    assign w_accept     = in_valid && in_ready;
    assign w_ign        = (in_data == CH_SP) || (in_data == CH_CR);
    assign w_digit_byte = is_digit(in_data);
    assign w_room       = r_fcnt < FC_W'(NUM_FIELDS);

    csv_dec_accum #(.FIELD_W(FIELD_W)) u_accum (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (w_commit || w_bad || w_rec_end),
        .i_set_neg  (w_set_neg),
        .i_digit_en (w_digit_en),
        .i_digit    (in_data[3:0]),
        .o_value    (w_value),
        .o_sat      (w_sat)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_commit    = 1'b0;
        w_set_neg   = 1'b0;
        w_digit_en  = 1'b0;
        w_bad       = 1'b0;
        w_rec_end   = 1'b0;
        w_seen_nxt  = r_seen;
        if (w_accept && !w_ign) begin
            if (in_data != CH_LF) begin
                w_seen_nxt = 1'b1;
            end
            case (r_state)
                FIELD_START: begin
                    if (in_data == CH_MINUS) begin
                        w_set_neg   = 1'b1;
                        w_state_nxt = DIGITS;
                    end else if (w_digit_byte) begin
                        w_digit_en  = 1'b1;
                        w_state_nxt = DIGITS;
                    end else if (in_data == CH_COMMA) begin
                        w_commit = 1'b1;
                    end else if (in_data == CH_LF) begin
                        // trailing comma leaves an empty last field; a bare line is dropped
                        w_commit  = r_seen;
                        w_rec_end = r_seen;
                    end else begin
                        w_bad       = 1'b1;
                        w_state_nxt = SKIP;
                    end
                end
                DIGITS: begin
                    if (w_digit_byte) begin
                        w_digit_en = 1'b1;
                    end else if (in_data == CH_COMMA) begin
                        w_commit    = 1'b1;
                        w_state_nxt = FIELD_START;
                    end else if (in_data == CH_LF) begin
                        w_commit    = 1'b1;
                        w_rec_end   = 1'b1;
                        w_state_nxt = FIELD_START;
                    end else begin
                        w_bad       = 1'b1;
                        w_state_nxt = SKIP;
                    end
                end
                SKIP: begin
                    if (in_data == CH_LF) begin
                        w_rec_end   = 1'b1;
                        w_state_nxt = FIELD_START;
                    end
                end
                default: w_state_nxt = FIELD_START;
            endcase
        end
    end

    always_comb begin
        w_fcnt_nxt   = r_fcnt + FC_W'(w_commit && w_room);
        w_rec_fields = r_wfields;
        for (int k = 0; k < NUM_FIELDS; k++) begin
            if (w_commit && (r_fcnt == FC_W'(k))) begin
                w_rec_fields[k*FIELD_W +: FIELD_W] = w_value;
            end
        end
        w_rec_err = r_err;
        w_rec_err[ERR_CHAR] = r_err[ERR_CHAR] | w_bad;
        w_rec_err[ERR_OVF]  = r_err[ERR_OVF] | w_sat;
        if ((w_commit && !w_room) || (w_rec_end && (w_fcnt_nxt < FC_W'(NUM_FIELDS)))) begin
            w_rec_err[ERR_CNT] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= FIELD_START;
            r_fcnt     <= '0;
            r_seen     <= 1'b0;
            r_err      <= '0;
            r_wfields  <= '0;
            out_valid  <= 1'b0;
            out_fields <= '0;
            out_err    <= '0;
            rec_count  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_rec_end) begin
                r_fcnt     <= '0;
                r_seen     <= 1'b0;
                r_err      <= '0;
                r_wfields  <= '0;
                out_fields <= w_rec_fields;
                out_err    <= w_rec_err;
                out_valid  <= 1'b1;
                rec_count  <= rec_count + CNT_W'(1);
            end else begin
                r_fcnt    <= w_fcnt_nxt;
                r_seen    <= w_seen_nxt;
                r_err     <= w_rec_err;
                r_wfields <= w_rec_fields;
                if (out_valid && out_ready) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/csv_record_parser.md
Name: csv_record_parser

Overview:
Streaming, synthesizable replacement for the bench-side fscanf path of the logged-data flow.
- Consumes an ASCII byte stream of comma-separated signed decimal integers, one record per line.
- Emits each record as NUM_FIELDS parallel FIELD_W-bit two's-complement fields, with a per-record error code.
- Sits between the UART/SD byte source and the AI inference front end, so dumped CSV logs replay in hardware.

Parameters:
- NUM_FIELDS, 5, number of integer fields per record.
- FIELD_W, 32, width of each parsed field, two's complement.
- CNT_W, 16, width of the wrapping record counter.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, synchronous active-high reset.
- in_data, input, 8, ASCII byte.
- in_valid, input, 1, in_data valid.
- in_ready, output, 1, parser accepts byte this cycle.
- out_fields, output, NUM_FIELDS*FIELD_W, field k in bits [k*FIELD_W +: FIELD_W]; field 0 is leftmost in the line.
- out_err, output, 3, bit0 bad character, bit1 overflow/saturation, bit2 field-count mismatch.
- out_valid, output, 1, record available.
- out_ready, input, 1, consumer accepts record.
- rec_count, output, CNT_W, records emitted since reset; wraps at 2^CNT_W.

Behaviour:
- Reset (synchronous, rst=1 at clk edge):
  - out_valid=0, out_fields=0, out_err=0, rec_count=0, state=FIELD_START.
  - Partial record discarded; in_ready=1 the cycle after reset releases.
- Handshake:
  - A byte is accepted when in_valid && in_ready.
  - in_ready = !out_valid || out_ready.
  - Record transfers on out_valid && out_ready. out_fields and out_err are held stable while out_valid=1 and out_ready=0.
- States:
  - FIELD_START: '-' sets neg and moves to DIGITS; digit loads acc and moves to DIGITS; ',' ends an empty field (value 0).
  - DIGITS: digit updates acc; ',' commits field, goes to FIELD_START; '\n' commits field and ends record.
  - SKIP: entered on a bad character; discards bytes until '\n', then ends the record.
  - Ignored in every state: ' ' and '\r'.
  - Any other byte (including '-' inside DIGITS): err0 set, go to SKIP.
- Digit arithmetic:
  - acc = acc*10 + digit, on an unsigned magnitude FIELD_W+4 bits wide.
  - Magnitude saturates at 2^(FIELD_W-1)-1 if positive, 2^(FIELD_W-1) if negative; saturation sets err1.
  - On commit, value = neg ? -mag : mag; acc and neg are then cleared.
- Field count:
  - Fields beyond NUM_FIELDS are parsed but discarded; sets err2.
  - Fewer than NUM_FIELDS at '\n': missing fields = 0; sets err2.
- Empty line: '\n' with no non-ignored byte since the last record start is dropped. No output, no count increment.
- Record end: on the cycle '\n' is accepted, the output register loads. out_valid=1 on the next cycle (latency 1 byte-cycle); rec_count increments in the same cycle.
- Working registers are independent of the output register, so the next byte can be accepted in the same cycle the record is consumed.
- Throughput: 1 byte/cycle.
- Error bits accumulate per record and clear when the next record starts.

Decomposition:
- Shared package csv_pkg:
  - ASCII constants: CH_COMMA, CH_LF, CH_CR, CH_SP, CH_MINUS, CH_0, CH_9.
  - Typedef parse_state_e {FIELD_START, DIGITS, SKIP}.
  - Error bit index constants ERR_CHAR, ERR_OVF, ERR_CNT.
- One sub-module, csv_dec_accum: owns acc/neg, digit multiply-add, saturation, and signed commit value.

Test Plan:
- "1,-2,30,4,5\n" with out_ready=1 -> one record {1,-2,30,4,5}, err=000, rec_count=1, out_valid one cycle after '\n'.
- "7,8\r\n" then "\n" -> record {7,8,0,0,0}, err=100; the empty line produces nothing; rec_count=1.
- "2147483648,-2147483649,1,2,3,9\n" -> {2147483647,-2147483648,1,2,3}, err=110.
- "12,a4,5,6,7\n" followed by "1,1,1,1,1\n" -> first record {12,0,0,0,0}, err=001 or 101 per count; second record clean, err=000.
- Two back-to-back records with out_ready held 0 for 20 cycles -> in_ready=0 after first '\n', first record stable; on release both emitted in order; no byte lost.
- rst pulsed mid-line "3,4" then "5,6,7,8,9\n" -> only {5,6,7,8,9} emitted, rec_count=1.
